// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and key map for the keypad digit controller
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // 16 entries of 4 bits, indexed by {row, col}; entry 0 sits in the LSBs.
    // Rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
    localparam logic [63:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_lookup(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [5:0] bit_idx;
        bit_idx = {row_idx, col_idx, 2'b00};
        return KEY_MAP[bit_idx +: 4];
    endfunction

endpackage

// File: rtl/keypad_decoder.sv
// rtl/keypad_decoder.sv - maps synchronized rows and active column to a key code
module keypad_decoder
    import keypad_pkg::*;
(
    input  logic [3:0] row_s,
    input  logic [1:0] col_idx,
    output logic [3:0] key
);

    logic [1:0] row_idx;

    // Lowest-index low row wins, so several keys in one column yield one key
    always_comb begin
        row_idx = 2'd3;
        if (!row_s[0]) begin
            row_idx = 2'd0;
        end else if (!row_s[1]) begin
            row_idx = 2'd1;
        end else if (!row_s[2]) begin
            row_idx = 2'd2;
        end
        key = key_lookup(row_idx, col_idx);
    end

endmodule

// File: rtl/keypad_digit_controller.sv
// rtl/keypad_digit_controller.sv - column scanner, debouncer and two-digit key history
module keypad_digit_controller
    import keypad_pkg::*;
#(
    parameter int SCAN_COUNT     = 50_000,
    parameter int DEBOUNCE_COUNT = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] digitL,
    output logic [3:0] digitR,
    output logic       keyValid
);

    localparam int MAX_COUNT = (SCAN_COUNT > DEBOUNCE_COUNT) ? SCAN_COUNT : DEBOUNCE_COUNT;
    localparam int CNT_W     = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_COUNT - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_COUNT - 1);
    // Rows are only trusted once the column drive has settled and passed the synchronizer
    localparam logic [CNT_W-1:0] SETTLE    = CNT_W'(3);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    logic [1:0]       c;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       row_meta;
    logic [3:0]       row_s;
    logic [3:0]       row_latch;
    logic [3:0]       key;

    keypad_decoder u_decoder (
        .row_s   (row_s),
        .col_idx (c),
        .key     (key)
    );

    // Exactly one column driven low, selected by the column register
    assign col = ~(4'b0001 << c);

    // Two-flop synchronizer for the asynchronous row inputs; idles high like the pull-ups
    always_ff @(posedge clk) begin
        if (!reset) begin
            row_meta <= 4'b1111;
            row_s    <= 4'b1111;
        end else begin
            row_meta <= row;
            row_s    <= row_meta;
        end
    end

    // Scan / debounce / held / release sequencing with registered digit history
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= SCAN;
            c         <= 2'd0;
            cnt       <= '0;
            row_latch <= 4'b1111;
            digitL    <= 4'd0;
            digitR    <= 4'd0;
            keyValid  <= 1'b0;
        end else begin
            keyValid <= 1'b0;
            case (state)
                SCAN: begin
                    if (cnt >= SETTLE && row_s != 4'b1111) begin
                        row_latch <= row_s;
                        cnt       <= '0;
                        state     <= DEBOUNCE;
                    end else if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        c   <= c + 2'd1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DEBOUNCE: begin
                    if (row_s != row_latch) begin
                        state <= SCAN;
                        c     <= c + 2'd1;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        digitL   <= digitR;
                        digitR   <= key;
                        keyValid <= 1'b1;
                        state    <= HELD;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (row_s == 4'b1111) begin
                        state <= RELEASE;
                        cnt   <= '0;
                    end
                end
                RELEASE: begin
                    if (row_s != 4'b1111) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= SCAN;
                        c     <= c + 2'd1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= SCAN;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_digit_controller.sv
// tb/tb_keypad_digit_controller.sv - scoreboard bench for keypad_digit_controller
module tb_keypad_digit_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] digitL;
    logic [3:0] digitR;
    logic       keyValid;

    logic [15:0] pressed = '0;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    logic [3:0]  model_r = 4'd0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_e;
    logic [3:0]  prev_col = 4'b1110;
    logic        prev_reset = 1'b0;
    logic [3:0]  kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};

    always #5 clk = ~clk;

    keypad_digit_controller #(
        .SCAN_COUNT     (8),
        .DEBOUNCE_COUNT (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .digitL   (digitL),
        .digitR   (digitR),
        .keyValid (keyValid)
    );

    // Keypad matrix: a pressed key pulls its row low while its column is driven
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && col[c] === 1'b0) begin
                    row[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_key(input int idx);
        exp_q.push_back({model_r, kmap[idx]});
        model_r = kmap[idx];
    endtask

    task automatic wait_accept(input int n0, input string tag);
        int i;
        i = 0;
        while (pulses == n0 && i < 150) begin
            tick();
            i++;
        end
        check(tag, 32'(pulses), 32'(n0 + 1));
    endtask

    task automatic wait_col(input logic [3:0] target);
        int i;
        i = 0;
        while (col === target && i < 40) begin
            tick();
            i++;
        end
        i = 0;
        while (col !== target && i < 40) begin
            tick();
            i++;
        end
        check("wait_col", 32'(col), 32'(target));
    endtask

    task automatic tap(input int idx, input int hold, input string tag);
        int n0;
        n0 = pulses;
        expect_key(idx);
        pressed[idx] = 1'b1;
        wait_accept(n0, {tag, "_accept"});
        repeat (hold) tick();
        pressed[idx] = 1'b0;
        repeat (40) tick();
        check({tag, "_once"}, 32'(pulses), 32'(n0 + 1));
    endtask

    // Scoreboard pop on every keyValid, plus column-drive sanity every cycle
    always @(negedge clk) begin
        if (keyValid === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("spurious_keyValid", 32'(keyValid), 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("sb_digitL", 32'(digitL), 32'(exp_e[7:4]));
                check("sb_digitR", 32'(digitR), 32'(exp_e[3:0]));
            end
        end
        if (reset === 1'b1 && prev_reset === 1'b1) begin
            check("col_onehot", 32'($countones(~col)), 32'd1);
            if (col !== prev_col) begin
                check("col_step", 32'(col), 32'({prev_col[2:0], prev_col[3]}));
            end
        end
        prev_col   = col;
        prev_reset = reset;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        logic [3:0] ec;

        reset   = 1'b0;
        pressed = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_col", 32'(col), 32'(4'b1110));
        check("rst_digitL", 32'(digitL), 32'd0);
        check("rst_digitR", 32'(digitR), 32'd0);
        check("rst_keyValid", 32'(keyValid), 32'd0);

        // Idle scan: each column held for 8 cycles, wrapping 3 -> 0
        @(posedge clk);
        #2 reset = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            ec = ~(4'b0001 << ((k / 8) % 4));
            check("idle_col", 32'(col), 32'(ec));
        end
        check("idle_no_pulse", 32'(pulses), 32'd0);

        // Single key "5", then "A", then "0"
        tap(5, 20, "key5");
        check("key5_L", 32'(digitL), 32'h0);
        check("key5_R", 32'(digitR), 32'h5);
        tap(3, 10, "keyA");
        check("keyA_L", 32'(digitL), 32'h5);
        check("keyA_R", 32'(digitR), 32'hA);
        tap(13, 10, "key0");
        check("key0_L", 32'(digitL), 32'hA);
        check("key0_R", 32'(digitR), 32'h0);

        // Bouncing "7": never stable long enough, scan moves on to column 1
        n0 = pulses;
        wait_col(4'b1110);
        for (int t = 0; t < 42; t++) begin
            pressed[8] = ((t % 7) < 5);
            tick();
            if (t == 9) check("bounce_next_col", 32'(col), 32'(4'b1101));
        end
        pressed[8] = 1'b0;
        repeat (40) tick();
        check("bounce_no_pulse", 32'(pulses), 32'(n0));
        check("bounce_digitR", 32'(digitR), 32'h0);

        // Hold "1", add "4" in the same column, release with bounce
        n0 = pulses;
        expect_key(0);
        pressed[0] = 1'b1;
        wait_accept(n0, "key1_accept");
        repeat (5) tick();
        pressed[4] = 1'b1;
        repeat (10) tick();
        pressed[4] = 1'b0;
        pressed[0] = 1'b0;
        for (int t = 0; t < 10; t++) begin
            pressed[0] = ((t % 2) == 1);
            tick();
        end
        pressed[0] = 1'b0;
        repeat (40) tick();
        check("key1_once", 32'(pulses), 32'(n0 + 1));
        check("key1_R", 32'(digitR), 32'h1);
        check("key1_L", 32'(digitL), 32'h0);

        // "2" and "8" together in column 1: lowest row wins
        n0 = pulses;
        expect_key(1);
        pressed[1] = 1'b1;
        pressed[9] = 1'b1;
        wait_accept(n0, "multi_accept");
        repeat (5) tick();
        pressed[1] = 1'b0;
        pressed[9] = 1'b0;
        repeat (40) tick();
        check("multi_once", 32'(pulses), 32'(n0 + 1));
        check("multi_R", 32'(digitR), 32'h2);

        // Reset 8 cycles into debouncing "9"
        n0 = pulses;
        wait_col(4'b1011);
        pressed[10] = 1'b1;
        repeat (12) tick();
        reset       = 1'b0;
        pressed[10] = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("mid_rst_col", 32'(col), 32'(4'b1110));
        check("mid_rst_L", 32'(digitL), 32'd0);
        check("mid_rst_R", 32'(digitR), 32'd0);
        check("mid_rst_kv", 32'(keyValid), 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        model_r = 4'd0;
        @(negedge clk);
        check("post_rst_col", 32'(col), 32'(4'b1110));
        repeat (40) tick();
        check("post_rst_no_pulse", 32'(pulses), 32'(n0));
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
